// File: rtl/acq_pkg.sv
// Shared types for the acquisition path: search FSM states, MF power width and peak report record.
package acq_pkg;

   localparam int MF_SUM_W = 24;
   localparam int PK_CNT_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      TUNE,
      FLUSH,
      DWELL,
      DECIDE,
      DONE
   } search_state_t;

   typedef struct packed {
      logic [PK_CNT_W-1:0] bin;
      logic [PK_CNT_W-1:0] phase;
      logic [MF_SUM_W-1:0] val;
   } pk_t;

endpackage

// File: rtl/mf_peak_track.sv
// Running maximum tracker: keeps the first strictly-largest value seen since the last clear, with its index.
module mf_peak_track #(
   parameter int VAL_W = 24,
   parameter int IDX_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clear,
   input  logic             i_vld,
   input  logic [VAL_W-1:0] i_val,
   input  logic [IDX_W-1:0] i_idx,
   output logic [VAL_W-1:0] o_max_val,
   output logic [IDX_W-1:0] o_max_idx
);

   logic [VAL_W-1:0] r_max_val;
   logic [IDX_W-1:0] r_max_idx;

   // Strict compare so that on equal values the earliest index is kept.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         r_max_val <= '0;
         r_max_idx <= '0;
      end else if (i_vld && (i_val > r_max_val)) begin
         r_max_val <= i_val;
         r_max_idx <= i_idx;
      end
   end

   assign o_max_val = r_max_val;
   assign o_max_idx = r_max_idx;

endmodule

// File: rtl/mf_search_ctrl.sv
// Matched-filter acquisition sequencer: steps NCO bins, flushes the MF, dwells and reports the peak.
// Optional MF_SEARCH_BEST_EN: on a failed search, report the best peak across all bins.
module mf_search_ctrl
   import acq_pkg::*;
#(
   parameter int PRBS_SIZE = 128,
   parameter int MF_LAT    = 11,
   parameter int FREQ_W    = 32,
   parameter int CNT_W     = PK_CNT_W
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_start,
   input  logic                i_abort,
   input  logic [FREQ_W-1:0]   i_cfg_f0,
   input  logic [FREQ_W-1:0]   i_cfg_fstep,
   input  logic [CNT_W-1:0]    i_cfg_nbins,
   input  logic [CNT_W-1:0]    i_cfg_dwell,
   input  logic [MF_SUM_W-1:0] i_cfg_thr,
   input  logic                i_s_vld,
   input  logic [MF_SUM_W-1:0] i_mf_sum,
   output logic [FREQ_W-1:0]   o_nco_freq,
   output logic                o_nco_load,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_found,
   output logic [CNT_W-1:0]    o_pk_bin,
   output logic [CNT_W-1:0]    o_pk_phase,
   output logic [MF_SUM_W-1:0] o_pk_val
);

   localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(PRBS_SIZE + MF_LAT - 1);

   search_state_t       r_state;
   search_state_t       w_next_state;
   logic [MF_LAT-1:0]   r_qpipe;
   logic                w_q_vld;
   logic [FREQ_W-1:0]   r_fstep;
   logic [FREQ_W-1:0]   r_freq;
   logic [FREQ_W-1:0]   r_nco_freq;
   logic [CNT_W-1:0]    r_nbins_m1;
   logic [CNT_W-1:0]    r_dwell_m1;
   logic [CNT_W-1:0]    r_bin;
   logic [CNT_W-1:0]    r_flush_cnt;
   logic [CNT_W-1:0]    r_dwell_cnt;
   logic [MF_SUM_W-1:0] r_thr;
   logic                r_nco_load;
   logic                r_found;
   logic                r_start_pend;
   pk_t                 r_pk;
   pk_t                 w_fail_pk;
   logic                w_accept;
   logic                w_hit;
   logic                w_last_bin;
   logic                w_bin_clr;
   logic                w_bin_vld;
   logic [MF_SUM_W-1:0] w_bin_max;
   logic [CNT_W-1:0]    w_bin_phase;

   assign w_q_vld    = r_qpipe[MF_LAT-1];
   assign w_hit      = (w_bin_max >= r_thr);
   assign w_last_bin = (r_bin == r_nbins_m1);
   assign w_bin_clr  = (r_state == TUNE);
   assign w_bin_vld  = (r_state == DWELL) && w_q_vld;

   mf_peak_track #(
      .VAL_W (MF_SUM_W),
      .IDX_W (CNT_W)
   ) u_bin_track (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_clear   (w_bin_clr),
      .i_vld     (w_bin_vld),
      .i_val     (i_mf_sum),
      .i_idx     (r_dwell_cnt),
      .o_max_val (w_bin_max),
      .o_max_idx (w_bin_phase)
   );

`ifdef MF_SEARCH_BEST_EN
   logic [MF_SUM_W-1:0] w_glob_max;
   logic [2*CNT_W-1:0]  w_glob_idx;

   mf_peak_track #(
      .VAL_W (MF_SUM_W),
      .IDX_W (2*CNT_W)
   ) u_glob_track (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_clear   (w_accept),
      .i_vld     (r_state == DECIDE),
      .i_val     (w_bin_max),
      .i_idx     ({r_bin, w_bin_phase}),
      .o_max_val (w_glob_max),
      .o_max_idx (w_glob_idx)
   );

   // The last bin is folded into the global tracker on the same edge, so compare it directly here.
   always_comb begin
      w_fail_pk = '0;
      if (w_bin_max > w_glob_max) begin
         w_fail_pk = pk_t'{bin: r_bin, phase: w_bin_phase, val: w_bin_max};
      end else begin
         w_fail_pk = pk_t'{bin: w_glob_idx[2*CNT_W-1:CNT_W], phase: w_glob_idx[CNT_W-1:0], val: w_glob_max};
      end
   end
`else
   assign w_fail_pk = '0;
`endif

   // A start seen during DONE is held in r_start_pend and taken up from IDLE.
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (i_start || r_start_pend) begin
               w_accept     = 1'b1;
               w_next_state = TUNE;
            end
         end
         TUNE:   w_next_state = FLUSH;
         FLUSH:  if (i_s_vld && (r_flush_cnt == FLUSH_LAST)) w_next_state = DWELL;
         DWELL:  if (w_q_vld && (r_dwell_cnt == r_dwell_m1)) w_next_state = DECIDE;
         DECIDE: w_next_state = (w_hit || w_last_bin) ? DONE : TUNE;
         DONE:   w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
      if (i_abort) begin
         w_next_state = IDLE;
         w_accept     = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= IDLE;
         r_qpipe      <= '0;
         r_fstep      <= '0;
         r_freq       <= '0;
         r_nco_freq   <= i_cfg_f0;
         r_nbins_m1   <= '0;
         r_dwell_m1   <= '0;
         r_bin        <= '0;
         r_flush_cnt  <= '0;
         r_dwell_cnt  <= '0;
         r_thr        <= '0;
         r_nco_load   <= 1'b0;
         r_found      <= 1'b0;
         r_start_pend <= 1'b0;
         r_pk         <= '0;
      end else begin
         r_state      <= w_next_state;
         r_qpipe      <= {r_qpipe[MF_LAT-2:0], i_s_vld};
         r_nco_load   <= 1'b0;
         r_start_pend <= (r_state == DONE) && i_start && !i_abort;
         if (w_accept) begin
            r_fstep    <= i_cfg_fstep;
            r_freq     <= i_cfg_f0;
            r_nbins_m1 <= (i_cfg_nbins == '0) ? '0 : i_cfg_nbins - 1'b1;
            r_dwell_m1 <= (i_cfg_dwell == '0) ? '0 : i_cfg_dwell - 1'b1;
            r_thr      <= i_cfg_thr;
            r_bin      <= '0;
            r_found    <= 1'b0;
            r_pk       <= '0;
         end
         if ((r_state == TUNE) && (w_next_state == FLUSH)) begin
            r_nco_freq  <= r_freq;
            r_nco_load  <= 1'b1;
            r_flush_cnt <= '0;
            r_dwell_cnt <= '0;
         end
         if ((r_state == FLUSH) && i_s_vld) begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
         end
         if (w_bin_vld) begin
            r_dwell_cnt <= r_dwell_cnt + 1'b1;
         end
         if ((r_state == DECIDE) && !i_abort) begin
            if (w_hit) begin
               r_found <= 1'b1;
               r_pk    <= pk_t'{bin: r_bin, phase: w_bin_phase, val: w_bin_max};
            end else if (w_last_bin) begin
               r_pk    <= w_fail_pk;
            end else begin
               r_bin   <= r_bin + 1'b1;
               r_freq  <= r_freq + r_fstep;
            end
         end
      end
   end

   assign o_nco_freq = r_nco_freq;
   assign o_nco_load = r_nco_load;
   assign o_busy     = (r_state == TUNE) || (r_state == FLUSH) || (r_state == DWELL) || (r_state == DECIDE);
   assign o_done     = (r_state == DONE);
   assign o_found    = r_found;
   assign o_pk_bin   = r_pk.bin;
   assign o_pk_phase = r_pk.phase;
   assign o_pk_val   = r_pk.val;

endmodule

// File: tb/tb_mf_search_ctrl.sv
// Directed bench for mf_search_ctrl; a behavioural MF stand-in feeds per-bin/per-phase power values.
`timescale 1ns/1ps
module tb_mf_search_ctrl;

   localparam int          MF_LAT    = 11;
   localparam int          FLUSH_LEN = 139;
   localparam logic [23:0] JUNK      = 24'hFFFFFF;

   logic        clk      = 1'b0;
   logic        rst      = 1'b1;
   logic        start    = 1'b0;
   logic        abort    = 1'b0;
   logic [31:0] cfgF0    = '0;
   logic [31:0] cfgFstep = '0;
   logic [15:0] cfgNbins = 16'd1;
   logic [15:0] cfgDwell = 16'd1;
   logic [23:0] cfgThr   = '0;
   logic        sVld     = 1'b0;
   logic [23:0] mfSum    = '0;

   logic [31:0] ncoFreq;
   logic        ncoLoad;
   logic        busy;
   logic        done;
   logic        found;
   logic [15:0] pkBinOut;
   logic [15:0] pkPhaseOut;
   logic [23:0] pkValOut;

   int vectors     = 0;
   int miscompares = 0;

   int          svldPeriod  = 1;
   int          cyc         = 0;
   int          loadCount   = 0;
   int          doneCount   = 0;
   int          curBin      = 0;
   int          flushCnt    = 0;
   int          phase       = 0;
   int          dwellLen    = 1;
   bit          flushActive = 1'b0;
   bit          inDwell     = 1'b0;
   logic [MF_LAT-1:0] hist  = '0;
   logic        newV;
   logic        qNow;
   logic [31:0] loadFreq [0:15];

   int          pkBin = 99;
   int          pkPh1 = 0;
   int          pkPh2 = 0;
   logic [23:0] pkVal = '0;

   mf_search_ctrl dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (start),
      .i_abort     (abort),
      .i_cfg_f0    (cfgF0),
      .i_cfg_fstep (cfgFstep),
      .i_cfg_nbins (cfgNbins),
      .i_cfg_dwell (cfgDwell),
      .i_cfg_thr   (cfgThr),
      .i_s_vld     (sVld),
      .i_mf_sum    (mfSum),
      .o_nco_freq  (ncoFreq),
      .o_nco_load  (ncoLoad),
      .o_busy      (busy),
      .o_done      (done),
      .o_found     (found),
      .o_pk_bin    (pkBinOut),
      .o_pk_phase  (pkPhaseOut),
      .o_pk_val    (pkValOut)
   );

   always #5 clk = ~clk;

   function automatic logic [23:0] sampleVal(input int b, input int p);
      if ((b == pkBin) && ((p == pkPh1) || (p == pkPh2))) return pkVal;
      return 24'(100 + ((b * 13 + p * 7) % 50));
   endfunction

   // MF stand-in: power of strobe k appears MF_LAT edges later; samples outside a bin's dwell window carry JUNK.
   always @(negedge clk) begin
      cyc++;
      newV = (svldPeriod != 0) && ((cyc % svldPeriod) == 0);
      qNow = hist[MF_LAT-1];
      hist = {hist[MF_LAT-2:0], newV};
      if (ncoLoad) begin
         if (loadCount < 16) loadFreq[loadCount] = ncoFreq;
         curBin      = loadCount;
         loadCount++;
         flushActive = 1'b1;
         flushCnt    = 0;
         inDwell     = 1'b0;
         phase       = 0;
      end
      if (done) doneCount++;
      if (inDwell && qNow) begin
         mfSum = sampleVal(curBin, phase);
         phase++;
         if (phase == dwellLen) inDwell = 1'b0;
      end else begin
         mfSum = JUNK;
      end
      if (flushActive && newV) begin
         flushCnt++;
         if (flushCnt == FLUSH_LEN) begin
            flushActive = 1'b0;
            inDwell     = 1'b1;
         end
      end
      sVld = newV;
   end

   task automatic applyStimulus(input logic [31:0] f0, input logic [31:0] fstep, input logic [15:0] nb,
                                input logic [15:0] dw, input logic [23:0] thr, input int period);
      @(negedge clk);
      cfgF0      = f0;
      cfgFstep   = fstep;
      cfgNbins   = nb;
      cfgDwell   = dw;
      cfgThr     = thr;
      svldPeriod = period;
      dwellLen   = (dw == 16'd0) ? 1 : int'(dw);
      loadCount  = 0;
      doneCount  = 0;
      start      = 1'b1;
      @(negedge clk);
      start      = 1'b0;
   endtask

   task automatic waitDone(input int maxCyc, input string name, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < maxCyc; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL %s: done not seen, got timeout after %0d cycles, expected done pulse", name, maxCyc);
      end
   endtask

   task automatic test_reset();
      cfgF0 = 32'hDEAD_BEEF;
      rst   = 1'b1;
      repeat (3) @(negedge clk);
      rst   = 1'b0;
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0 || found !== 1'b0 || ncoLoad !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_flags: got busy=%b done=%b found=%b load=%b, expected all 0", busy, done, found, ncoLoad);
      end
      vectors++;
      if (ncoFreq !== 32'hDEAD_BEEF) begin
         miscompares++;
         $display("[TB] FAIL reset_freq: got %h, expected deadbeef", ncoFreq);
      end
      vectors++;
      if (pkBinOut !== 16'd0 || pkPhaseOut !== 16'd0 || pkValOut !== 24'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_pk: got %0d/%0d/%0d, expected 0/0/0", pkBinOut, pkPhaseOut, pkValOut);
      end
   endtask

   task automatic test_search_hit();
      bit seen;
      pkBin = 3; pkPh1 = 40; pkPh2 = 40; pkVal = 24'd5000;
      applyStimulus(32'h1000_0000, 32'h0010_0000, 16'd8, 16'd64, 24'd4000, 1);
      for (int i = 0; i < 10 && loadCount == 0; i++) @(negedge clk);
      cfgThr = 24'd1; cfgNbins = 16'd1; cfgDwell = 16'd2; cfgFstep = '0;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      waitDone(4000, "hit_done", seen);
      repeat (3) @(negedge clk);
      vectors++;
      if (found !== 1'b1 || pkBinOut !== 16'd3) begin
         miscompares++;
         $display("[TB] FAIL hit_bin: got found=%b bin=%0d, expected found=1 bin=3", found, pkBinOut);
      end
      vectors++;
      if (pkPhaseOut !== 16'd40 || pkValOut !== 24'd5000) begin
         miscompares++;
         $display("[TB] FAIL hit_peak: got phase=%0d val=%0d, expected phase=40 val=5000", pkPhaseOut, pkValOut);
      end
      vectors++;
      if (loadCount != 4 || doneCount != 1) begin
         miscompares++;
         $display("[TB] FAIL hit_counts: got loads=%0d dones=%0d, expected loads=4 dones=1", loadCount, doneCount);
      end
      vectors++;
      if (loadFreq[3] !== 32'h1030_0000 || ncoFreq !== 32'h1030_0000 || busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL hit_freq: got load3=%h freq=%h busy=%b, expected 10300000 10300000 0", loadFreq[3], ncoFreq, busy);
      end
   endtask

   task automatic test_no_detect();
      bit seen;
      pkBin = 2; pkPh1 = 10; pkPh2 = 10; pkVal = 24'd3000;
      applyStimulus(32'h0000_1000, 32'h0000_0100, 16'd4, 16'd32, 24'd4000, 2);
      waitDone(3000, "nodet_done", seen);
      repeat (3) @(negedge clk);
      vectors++;
      if (loadCount != 4 || found !== 1'b0 || loadFreq[3] !== 32'h0000_1300) begin
         miscompares++;
         $display("[TB] FAIL nodet_loads: got loads=%0d found=%b freq3=%h, expected 4 0 00001300", loadCount, found, loadFreq[3]);
      end
`ifdef MF_SEARCH_BEST_EN
      vectors++;
      if (pkBinOut !== 16'd2 || pkPhaseOut !== 16'd10 || pkValOut !== 24'd3000) begin
         miscompares++;
         $display("[TB] FAIL nodet_best: got %0d/%0d/%0d, expected 2/10/3000", pkBinOut, pkPhaseOut, pkValOut);
      end
`else
      vectors++;
      if (pkBinOut !== 16'd0 || pkPhaseOut !== 16'd0 || pkValOut !== 24'd0) begin
         miscompares++;
         $display("[TB] FAIL nodet_pk: got %0d/%0d/%0d, expected 0/0/0", pkBinOut, pkPhaseOut, pkValOut);
      end
`endif
   endtask

   task automatic test_equal_peaks();
      bit seen;
      pkBin = 0; pkPh1 = 5; pkPh2 = 9; pkVal = 24'd700;
      applyStimulus(32'h0000_0000, 32'h0000_0010, 16'd2, 16'd16, 24'd600, 3);
      waitDone(2000, "tie_done", seen);
      repeat (2) @(negedge clk);
      vectors++;
      if (found !== 1'b1 || pkBinOut !== 16'd0 || pkPhaseOut !== 16'd5 || pkValOut !== 24'd700) begin
         miscompares++;
         $display("[TB] FAIL tie_first: got found=%b %0d/%0d/%0d, expected 1 0/5/700", found, pkBinOut, pkPhaseOut, pkValOut);
      end
   endtask

   task automatic test_flush_boundary();
      bit seen;
      pkBin = 0; pkPh1 = 0; pkPh2 = 0; pkVal = 24'd900;
      applyStimulus(32'h0000_0040, 32'h0000_0010, 16'd1, 16'd8, 24'd800, 3);
      waitDone(2000, "flush_done", seen);
      repeat (2) @(negedge clk);
      vectors++;
      if (found !== 1'b1 || pkPhaseOut !== 16'd0 || pkValOut !== 24'd900) begin
         miscompares++;
         $display("[TB] FAIL flush_edge: got found=%b phase=%0d val=%0d, expected 1 0 900", found, pkPhaseOut, pkValOut);
      end
   endtask

   task automatic test_abort();
      int lc;
      pkBin = 99;
      applyStimulus(32'h0, 32'h1, 16'd8, 16'd64, 24'hFFFFFF, 1);
      for (int i = 0; i < 2000 && loadCount < 3; i++) @(negedge clk);
      repeat (FLUSH_LEN + 10) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL abort_busy: got busy=%b, expected 0", busy);
      end
      lc = loadCount;
      repeat (600) @(negedge clk);
      vectors++;
      if (lc != 3 || loadCount != 3 || doneCount != 0 || found !== 1'b0 || pkValOut !== 24'd0) begin
         miscompares++;
         $display("[TB] FAIL abort_quiet: got loads=%0d->%0d dones=%0d found=%b val=%0d, expected 3 3 0 0 0",
                  lc, loadCount, doneCount, found, pkValOut);
      end
   endtask

   task automatic test_fstep_wrap();
      bit seen;
      pkBin = 99;
      applyStimulus(32'h0000_0000, 32'hFFFF_FFFF, 16'd2, 16'd4, 24'hFFFFFF, 1);
      waitDone(1000, "wrap_done", seen);
      repeat (2) @(negedge clk);
      vectors++;
      if (loadCount != 2 || loadFreq[0] !== 32'h0 || loadFreq[1] !== 32'hFFFF_FFFF || found !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL wrap_freq: got loads=%0d f0=%h f1=%h found=%b, expected 2 00000000 ffffffff 0",
                  loadCount, loadFreq[0], loadFreq[1], found);
      end
   endtask

   task automatic test_reset_midflush();
      pkBin = 99;
      applyStimulus(32'h0000_5000, 32'h10, 16'd4, 16'd64, 24'hFFFFFF, 1);
      for (int i = 0; i < 10 && loadCount == 0; i++) @(negedge clk);
      repeat (20) @(negedge clk);
      cfgF0 = 32'h0BAD_F00D;
      rst   = 1'b1;
      start = 1'b1;
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      vectors++;
      if (busy !== 1'b0 || found !== 1'b0 || ncoLoad !== 1'b0 || ncoFreq !== 32'h0BAD_F00D) begin
         miscompares++;
         $display("[TB] FAIL rst_mid: got busy=%b found=%b load=%b freq=%h, expected 0 0 0 0badf00d",
                  busy, found, ncoLoad, ncoFreq);
      end
      loadCount = 0;
      repeat (300) @(negedge clk);
      vectors++;
      if (loadCount != 0 || busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL rst_idle: got loads=%0d busy=%b, expected 0 0", loadCount, busy);
      end
   endtask

   task automatic test_back_to_back();
      bit seen;
      pkBin = 99;
      applyStimulus(32'h0000_0100, 32'h10, 16'd1, 16'd4, 24'd0, 1);
      seen = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      vectors++;
      if (!seen) begin
         miscompares++;
         $display("[TB] FAIL b2b_first: got timeout, expected done pulse");
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL b2b_idle: got busy=%b, expected 0", busy);
      end
      @(negedge clk);
      loadCount = 0;
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL b2b_restart: got busy=%b, expected 1", busy);
      end
      waitDone(400, "b2b_second", seen);
      repeat (2) @(negedge clk);
      vectors++;
      if (doneCount != 2 || loadCount != 1 || found !== 1'b1 || pkPhaseOut !== 16'd3 || pkValOut !== 24'd121) begin
         miscompares++;
         $display("[TB] FAIL b2b_result: got dones=%0d loads=%0d found=%b phase=%0d val=%0d, expected 2 1 1 3 121",
                  doneCount, loadCount, found, pkPhaseOut, pkValOut);
      end
   endtask

   initial begin
      test_reset();
      test_search_hit();
      test_no_detect();
      test_equal_peaks();
      test_flush_boundary();
      test_abort();
      test_fstep_wrap();
      test_reset_midflush();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
